// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-FF input sync and mid-bit sampling.
// Feeds one byte per frame to the downstream FIFO controller.
//
// Ports:
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   rx        in   asynchronous serial line, idle high
//   data      out  last correctly framed byte, LSB received first
//   rx_ready  out  one-cycle strobe, data freshly updated
//   frame_err out  one-cycle strobe, stop bit sampled low
//   busy      out  high from start detection until back in IDLE
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_ready,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] HALF_END =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END =
    CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             rx_m;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             half_hit;
  logic             bit_hit;

  assign half_hit = (cnt == HALF_END);
  assign bit_hit  = (cnt == BIT_END);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (!rx_s) state_n = START;
      // Re-check at mid start bit to reject glitches.
      START:
        if (half_hit) state_n = rx_s ? IDLE : DATA;
      DATA:
        if (bit_hit && bit_idx == 3'd7) state_n = STOP;
      // Leaving at mid stop leaves half a bit
      // to catch a back-to-back start edge.
      STOP:
        if (bit_hit) state_n = rx_s ? IDLE : WAIT_IDLE;
      // A held-low break must not retrigger START.
      WAIT_IDLE:
        if (rx_s) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_ready  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: cnt <= '0;
        START: begin
          if (half_hit) begin
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_hit) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_hit) begin
            cnt <= '0;
            if (rx_s) begin
              data     <= shreg;
              rx_ready <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: cnt <= '0;
        default:   cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a byte scoreboard.
// Bytes are queued when sent and popped on each rx_ready.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       rx_ready;
  logic       frame_err;
  logic       busy;

  int         checks  = 0;
  int         errors  = 0;
  int         cyc     = 0;
  int         t_start = 0;
  int         lat     = 0;
  int         rdy_cnt = 0;
  int         fe_cnt  = 0;
  int         rdy0;
  int         fe0;
  logic       prev_rdy = 1'b0;
  logic       prev_fe  = 1'b0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit uses pa, then bit periods alternate pb, pa, ...
  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            input int pa,
                            input int pb);
    t_start = cyc;
    rx = 1'b0;
    wait_clk(pa);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk((i % 2 == 0) ? pb : pa);
    end
    rx = stop;
    wait_clk(pb);
  endtask

  always @(negedge clk) begin
    if (rx_ready) begin
      rdy_cnt++;
      lat = cyc - t_start;
      check("ready_excl", {31'b0, frame_err}, 0);
      check("ready_width", {31'b0, prev_rdy}, 0);
      check("ready_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_b = sb.pop_front();
        check("data", {24'b0, data}, {24'b0, exp_b});
      end
    end
    if (frame_err) begin
      fe_cnt++;
      check("ferr_width", {31'b0, prev_fe}, 0);
    end
    prev_rdy = rx_ready;
    prev_fe  = frame_err;
  end

  initial begin
    @(posedge clk);
    #1;
    wait_clk(3);
    check("rst_data", {24'b0, data}, 0);
    check("rst_ready", {31'b0, rx_ready}, 0);
    check("rst_ferr", {31'b0, frame_err}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    rst = 1'b0;
    wait_clk(5);

    // 1: single frame 0x55
    rdy0 = rdy_cnt;
    fe0  = fe_cnt;
    sb.push_back(8'h55);
    send_frame(8'h55, 1'b1, CPB, CPB);
    wait_clk(20);
    check("t1_ready_cnt", rdy_cnt, rdy0 + 1);
    check("t1_ferr_cnt", fe_cnt, fe0);
    check("t1_data", {24'b0, data}, 32'h55);
    check("t1_busy", {31'b0, busy}, 0);
    check("t1_latency", (lat >= 153 && lat <= 155), 1);

    // 2: start glitch
    rdy0 = rdy_cnt;
    rx = 1'b0;
    wait_clk(5);
    rx = 1'b1;
    wait_clk(8);
    check("t2_busy", {31'b0, busy}, 0);
    wait_clk(30);
    check("t2_ready_cnt", rdy_cnt, rdy0);
    check("t2_ferr_cnt", fe_cnt, fe0);

    // 3: framing error followed by a break
    send_frame(8'hA5, 1'b0, CPB, CPB);
    wait_clk(40);
    check("t3_busy_hold", {31'b0, busy}, 1);
    check("t3_ferr_cnt", fe_cnt, fe0 + 1);
    rx = 1'b1;
    wait_clk(4);
    check("t3_busy_rel", {31'b0, busy}, 0);
    wait_clk(40);
    check("t3_ready_cnt", rdy_cnt, rdy0);
    check("t3_ferr_once", fe_cnt, fe0 + 1);
    check("t3_data_kept", {24'b0, data}, 32'h55);

    // 4: back-to-back frames
    rdy0 = rdy_cnt;
    fe0  = fe_cnt;
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    send_frame(8'h00, 1'b1, CPB, CPB);
    send_frame(8'hFF, 1'b1, CPB, CPB);
    wait_clk(20);
    check("t4_ready_cnt", rdy_cnt, rdy0 + 2);
    check("t4_data", {24'b0, data}, 32'hFF);

    // 5: reset during data bit 4 of 0x81
    rdy0 = rdy_cnt;
    rx = 1'b0;
    wait_clk(CPB);
    rx = 1'b1;
    wait_clk(CPB);
    rx = 1'b0;
    wait_clk(3 * CPB);
    wait_clk(8);
    rst = 1'b1;
    wait_clk(2);
    check("t5_rst_data", {24'b0, data}, 0);
    check("t5_rst_busy", {31'b0, busy}, 0);
    rx  = 1'b1;
    rst = 1'b0;
    wait_clk(20);
    check("t5_no_ready", rdy_cnt, rdy0);
    check("t5_data_zero", {24'b0, data}, 0);
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, CPB, CPB);
    wait_clk(20);
    check("t5_ready_cnt", rdy_cnt, rdy0 + 1);
    check("t5_data", {24'b0, data}, 32'h3C);

    // 6: bit periods of 15 and 17 clocks
    rdy0 = rdy_cnt;
    fe0  = fe_cnt;
    sb.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 15, 17);
    wait_clk(20);
    check("t6a_data", {24'b0, data}, 32'hC3);
    sb.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 17, 15);
    wait_clk(20);
    check("t6_ready_cnt", rdy_cnt, rdy0 + 2);
    check("t6_ferr_cnt", fe_cnt, fe0);
    check("t6_data", {24'b0, data}, 32'hC3);

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
